// File: rtl/slave_out_port.sv
// Serial output port: loads a word on tx_start, waits for the master handshake,
// then shifts it out LSB first. Optional handshake timeout via SLAVE_OUT_TIMEOUT_EN.
module slave_out_port #(
  parameter int unsigned DATA_LEN    = 8,
  parameter int unsigned TIMEOUT_LEN = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [DATA_LEN-1:0] data_in,
  input  logic                tx_start,
  input  logic                master_ready,
  output logic                tx_data,
  output logic                slave_valid,
  output logic                tx_done,
  output logic                busy,
  output logic                tx_error
);

  localparam int unsigned CNT_W = $clog2(DATA_LEN);
  localparam int unsigned TMO_W = (TIMEOUT_LEN > 1) ? $clog2(TIMEOUT_LEN) : 1;

  // Elaboration-time parameter sanity checks.
  if (DATA_LEN < 2) begin : g_bad_data_len
    $error("slave_out_port: DATA_LEN must be >= 2");
  end
  if (TIMEOUT_LEN < 1) begin : g_bad_timeout_len
    $error("slave_out_port: TIMEOUT_LEN must be >= 1");
  end

  typedef enum logic [1:0] {
    IDLE           = 2'd0,
    WAIT_HANDSHAKE = 2'd1,
    SEND_DATA      = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_LEN-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                valid_q, valid_d;
  logic                done_q, done_d;
`ifdef SLAVE_OUT_TIMEOUT_EN
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic                error_q, error_d;
`endif

  // Next-state and output decode.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    count_d = count_q;
    valid_d = 1'b0;
    done_d  = 1'b0;
`ifdef SLAVE_OUT_TIMEOUT_EN
    tmo_d   = '0;
    error_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (tx_start) begin
          shift_d = data_in;
          count_d = '0;
          valid_d = 1'b1;
          state_d = WAIT_HANDSHAKE;
        end
      end
      WAIT_HANDSHAKE: begin
        if (valid_q && master_ready) begin
          shift_d = shift_q >> 1;
          count_d = CNT_W'(1);
          state_d = SEND_DATA;
        end else begin
          valid_d = 1'b1;
`ifdef SLAVE_OUT_TIMEOUT_EN
          // A handshake on the final wait cycle takes the branch above, so it wins.
          if (tmo_q == TMO_W'(TIMEOUT_LEN - 1)) begin
            valid_d = 1'b0;
            error_d = 1'b1;
            state_d = IDLE;
          end else begin
            tmo_d = tmo_q + TMO_W'(1);
          end
`endif
        end
      end
      SEND_DATA: begin
        shift_d = shift_q >> 1;
        if (count_q == CNT_W'(DATA_LEN - 1)) begin
          count_d = '0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          count_d = count_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
`ifdef SLAVE_OUT_TIMEOUT_EN
      tmo_q   <= '0;
      error_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      count_q <= count_d;
      valid_q <= valid_d;
      done_q  <= done_d;
`ifdef SLAVE_OUT_TIMEOUT_EN
      tmo_q   <= tmo_d;
      error_q <= error_d;
`endif
    end
  end

  assign tx_data     = shift_q[0];
  assign slave_valid = valid_q;
  assign tx_done     = done_q;
  assign busy        = (state_q != IDLE);
`ifdef SLAVE_OUT_TIMEOUT_EN
  assign tx_error    = error_q;
`else
  assign tx_error    = 1'b0;
`endif

endmodule

// File: tb/tb_slave_out_port.sv
// Directed bench for slave_out_port: table of words with hand-computed serial
// order, plus hand-written reset, back-to-back and handshake-timeout sequences.
module tb_slave_out_port;

  localparam int unsigned DL = 8;
  localparam int unsigned TL = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [DL-1:0] data_in;
  logic          tx_start;
  logic          master_ready;
  logic          tx_data;
  logic          slave_valid;
  logic          tx_done;
  logic          busy;
  logic          tx_error;

  int errors = 0;
  int checks = 0;

  slave_out_port #(.DATA_LEN(DL), .TIMEOUT_LEN(TL)) dut (
    .clk          (clk),
    .reset        (reset),
    .data_in      (data_in),
    .tx_start     (tx_start),
    .master_ready (master_ready),
    .tx_data      (tx_data),
    .slave_valid  (slave_valid),
    .tx_done      (tx_done),
    .busy         (busy),
    .tx_error     (tx_error)
  );

  always #5 clk = ~clk;

  // exp_seq holds the serial bits in transmission order, first bit at [7].
  typedef struct {
    logic [7:0] data;
    int         wait_n;
    bit         toggle;
    bit         inject;
    logic [7:0] exp_seq;
    int         exp_valid;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge where tx_done should be high.
  task automatic run_word(input logic [7:0] d, input int wait_n, input bit toggle,
                          input bit inject, input logic [7:0] exp_seq,
                          input int exp_valid, input string tag);
    int         vcnt;
    logic [7:0] rx;
    bit         bad;
    bit         errseen;
    vcnt = 0; rx = '0; bad = 1'b0; errseen = 1'b0;
    data_in = d; tx_start = 1'b1; master_ready = 1'b0;
    @(negedge clk);
    tx_start = 1'b0;
    data_in  = ~d;
    for (int i = 0; i < wait_n; i++) begin
      if (slave_valid) vcnt++;
      if (!busy || tx_done) bad = 1'b1;
      errseen |= tx_error;
      @(negedge clk);
    end
    master_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (slave_valid) vcnt++;
      rx = {rx[6:0], tx_data};
      if (!busy || tx_done) bad = 1'b1;
      errseen |= tx_error;
      if (k > 0 && toggle) master_ready = ~master_ready;
      if (inject && k == 2) begin
        data_in  = 8'hFF;
        tx_start = 1'b1;
      end else begin
        tx_start = 1'b0;
      end
      @(negedge clk);
    end
    tx_start = 1'b0; master_ready = 1'b0;
    check({tag, " valid_cycles"}, 32'(vcnt), 32'(exp_valid));
    check({tag, " rx_seq"}, 32'(rx), 32'(exp_seq));
    check({tag, " busy_during"}, 32'(bad), 32'd0);
    check({tag, " done_state"}, {28'd0, tx_done, busy, slave_valid, tx_data}, 32'b1000);
    check({tag, " no_error"}, 32'(errseen | tx_error), 32'd0);
  endtask

  task automatic check_idle(input string name);
    @(negedge clk);
    check(name, {27'd0, tx_done, busy, slave_valid, tx_data, tx_error}, 32'd0);
  endtask

  initial begin
    vecs[0] = '{8'hA5, 0, 1'b0, 1'b0, 8'b10100101, 1};
    vecs[1] = '{8'h3C, 4, 1'b1, 1'b0, 8'b00111100, 5};
    vecs[2] = '{8'h0F, 0, 1'b0, 1'b1, 8'b11110000, 1};
    vecs[3] = '{8'h01, 2, 1'b0, 1'b0, 8'b10000000, 3};
    vecs[4] = '{8'h80, 0, 1'b1, 1'b0, 8'b00000001, 1};

    reset = 1'b1; data_in = 8'h5A; tx_start = 1'b1; master_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_outputs", {27'd0, tx_done, busy, slave_valid, tx_data, tx_error}, 32'd0);
    reset = 1'b0; tx_start = 1'b0; master_ready = 1'b0;
    data_in = 8'hFF;
    check_idle("idle_ignores_data");

    for (int v = 0; v < 5; v++) begin
      run_word(vecs[v].data, vecs[v].wait_n, vecs[v].toggle, vecs[v].inject,
               vecs[v].exp_seq, vecs[v].exp_valid, $sformatf("vec%0d", v));
      check_idle($sformatf("vec%0d idle_after", v));
    end

    // Back-to-back: second request lands in the tx_done cycle.
    run_word(8'hC3, 0, 1'b0, 1'b0, 8'b11000011, 1, "b2b_first");
    run_word(8'h5A, 1, 1'b0, 1'b0, 8'b01011010, 2, "b2b_second");
    check_idle("b2b idle_after");

    // Reset three cycles into SEND_DATA aborts silently.
    begin
      bit saw_done;
      saw_done = 1'b0;
      data_in = 8'h96; tx_start = 1'b1; master_ready = 1'b1;
      @(negedge clk);
      tx_start = 1'b0;
      repeat (4) @(negedge clk);
      check("mid_send busy", 32'(busy), 32'd1);
      reset = 1'b1;
      @(negedge clk);
      check("mid_send reset_outputs",
            {27'd0, tx_done, busy, slave_valid, tx_data, tx_error}, 32'd0);
      reset = 1'b0;
      repeat (10) begin
        @(negedge clk);
        saw_done |= tx_done | tx_error | busy;
      end
      check("mid_send no_done", 32'(saw_done), 32'd0);
      run_word(8'h6B, 0, 1'b0, 1'b0, 8'b11010110, 1, "after_reset");
      check_idle("after_reset idle_after");
    end

`ifdef SLAVE_OUT_TIMEOUT_EN
    begin
      bit bad;
      bad = 1'b0;
      data_in = 8'h5A; tx_start = 1'b1; master_ready = 1'b0;
      @(negedge clk);
      tx_start = 1'b0;
      for (int i = 0; i < 15; i++) begin
        if (!slave_valid || tx_error || !busy) bad = 1'b1;
        @(negedge clk);
      end
      check("tmo waiting", 32'(bad), 32'd0);
      @(negedge clk);
      check("tmo pulse", {28'd0, tx_error, slave_valid, busy, tx_done}, 32'b1000);
      check_idle("tmo pulse_end");
      run_word(8'h3C, 15, 1'b0, 1'b0, 8'b00111100, 16, "tmo_last_cycle");
      check_idle("tmo_last_cycle idle_after");
    end
`else
    run_word(8'hA5, 20, 1'b0, 1'b0, 8'b10100101, 21, "long_wait");
    check_idle("long_wait idle_after");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
